// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared constants, pixel type and capture state enum
package video_pkg;

    localparam int IMG_W        = 640;
    localparam int IMG_H        = 480;
    localparam int FRAME_PIXELS = IMG_W * IMG_H;
    localparam int DATA_W       = 8;

    typedef logic [DATA_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } cap_state_e;

endpackage

// File: rtl/video_frame_capture_if.sv
// rtl/video_frame_capture_if.sv - pixel stream in, frame-memory write port out
interface video_frame_capture_if
    import video_pkg::*;
#(
    parameter int ADDR_W = 19
);
    pixel_t              s_data;
    logic                s_valid;
    logic                s_last;
    logic                s_ready;
    logic                mem_stall;
    logic                wr_en;
    logic [ADDR_W-1:0]   wr_addr;
    pixel_t              wr_data;
    logic [9:0]          pix_x;
    logic [8:0]          pix_y;

    modport master (
        output s_data, s_valid, s_last, mem_stall,
        input  s_ready, wr_en, wr_addr, wr_data, pix_x, pix_y
    );

    modport slave (
        input  s_data, s_valid, s_last, mem_stall,
        output s_ready, wr_en, wr_addr, wr_data, pix_x, pix_y
    );
endinterface

// File: rtl/pixel_xy_counter.sv
// rtl/pixel_xy_counter.sv - linear pixel index with x/y raster coordinates
module pixel_xy_counter #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] cnt,
    output logic [9:0]        x,
    output logic [8:0]        y,
    output logic              term
);
    localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [9:0]        LAST_X   = 10'(IMG_W - 1);

    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [9:0]        x_q, x_d;
    logic [8:0]        y_q, y_d;

    assign term = (cnt_q == LAST_CNT);

    // The counter parks on the final pixel so it can never run past the frame.
    always_comb begin
        cnt_d = cnt_q;
        x_d   = x_q;
        y_d   = y_q;
        if (clr) begin
            cnt_d = '0;
            x_d   = '0;
            y_d   = '0;
        end else if (inc && !term) begin
            cnt_d = cnt_q + 1'b1;
            if (x_q == LAST_X) begin
                x_d = '0;
                y_d = y_q + 9'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            x_q   <= x_d;
            y_q   <= y_d;
        end
    end

    assign cnt = cnt_q;
    assign x   = x_q;
    assign y   = y_q;
endmodule

// File: rtl/video_frame_capture.sv
// rtl/video_frame_capture.sv - captures one streamed frame per start into frame memory
module video_frame_capture
    import video_pkg::*;
#(
    parameter int IMG_W  = video_pkg::IMG_W,
    parameter int IMG_H  = video_pkg::IMG_H,
    parameter int ADDR_W = 19
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    video_frame_capture_if.slave    bus,
    output logic                    busy,
    output logic                    done,
    output logic                    err_early_last,
    output logic                    err_late_last,
    output logic [31:0]             frame_sum
);
    cap_state_e        state_q, state_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    pixel_t            wr_data_q, wr_data_d;
    logic [9:0]        pix_x_q, pix_x_d;
    logic [8:0]        pix_y_q, pix_y_d;
    logic [31:0]       sum_q, sum_d;
    logic              early_q, early_d;
    logic              late_q, late_d;

    logic              cnt_clr, cnt_inc, cnt_term, accept;
    logic [ADDR_W-1:0] cnt;
    logic [9:0]        x;
    logic [8:0]        y;

    pixel_xy_counter #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)) u_xy (
        .clk  (clk),
        .rst  (rst),
        .clr  (cnt_clr),
        .inc  (cnt_inc),
        .cnt  (cnt),
        .x    (x),
        .y    (y),
        .term (cnt_term)
    );

    assign busy        = (state_q == RECV) || (state_q == FLUSH);
    assign done        = (state_q == DONE);
    assign bus.s_ready = busy && !bus.mem_stall;
    assign accept      = bus.s_valid && bus.s_ready;

    always_comb begin
        state_d   = state_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        pix_x_d   = pix_x_q;
        pix_y_d   = pix_y_q;
        sum_d     = sum_q;
        early_d   = early_q;
        late_d    = late_q;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RECV;
                    cnt_clr = 1'b1;
                    sum_d   = '0;
                    early_d = 1'b0;
                    late_d  = 1'b0;
                end
            end
            RECV: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt;
                    wr_data_d = bus.s_data;
                    pix_x_d   = x;
                    pix_y_d   = y;
                    sum_d     = sum_q + 32'(bus.s_data);
                    cnt_inc   = 1'b1;
                    if (bus.s_last) begin
                        early_d = early_q | !cnt_term;
                        state_d = DONE;
                    end else if (cnt_term) begin
                        late_d  = 1'b1;
                        state_d = FLUSH;
                    end
                end
            end
            // Overlong frame: drain the source up to its last marker without writing.
            FLUSH: begin
                if (accept && bus.s_last) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            pix_x_q   <= '0;
            pix_y_q   <= '0;
            sum_q     <= '0;
            early_q   <= 1'b0;
            late_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            pix_x_q   <= pix_x_d;
            pix_y_q   <= pix_y_d;
            sum_q     <= sum_d;
            early_q   <= early_d;
            late_q    <= late_d;
        end
    end

    assign bus.wr_en    = wr_en_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.pix_x    = pix_x_q;
    assign bus.pix_y    = pix_y_q;
    assign frame_sum    = sum_q;
    assign err_early_last = early_q;
    assign err_late_last  = late_q;
endmodule

// File: tb/tb_video_frame_capture.sv
// tb/tb_video_frame_capture.sv - randomized frames against a beat-level reference model
module tb_video_frame_capture;
    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, err_early_last, err_late_last;
    logic [31:0] frame_sum;

    video_frame_capture_if #(.ADDR_W(19)) vif ();

    video_frame_capture #(.IMG_W(W), .IMG_H(H), .ADDR_W(19)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .bus            (vif),
        .busy           (busy),
        .done           (done),
        .err_early_last (err_early_last),
        .err_late_last  (err_late_last),
        .frame_sum      (frame_sum)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [7:0]  beat_data [0:31];
    int          nbeats, last_at, b;
    // reference model of one frame
    bit          in_frame, flushing, exp_early, exp_late;
    int          wcount, last_addr;
    logic [31:0] exp_sum;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        vif.s_valid   = 1'b0;
        vif.s_data    = 8'h00;
        vif.s_last    = 1'b0;
        vif.mem_stall = 1'b0;
    endtask

    task automatic run_cycle(input bit stall_toggle, input bit gaps, input bit rnd_start);
        bit         acc, exp_w, exp_done;
        int         a;
        logic [7:0] d;
        vif.mem_stall = stall_toggle ? 1'(cyc % 2) : 1'b0;
        cyc++;
        vif.s_valid = (b < nbeats) && (!gaps || $urandom_range(0, 2) != 0);
        vif.s_data  = vif.s_valid ? beat_data[b] : 8'($urandom);
        vif.s_last  = vif.s_valid ? (b == last_at - 1) : 1'($urandom);
        start       = rnd_start && in_frame && ($urandom_range(0, 3) == 0);
        #1;
        chk("busy", busy, in_frame);
        chk("s_ready", vif.s_ready, in_frame && !vif.mem_stall);
        acc = vif.s_valid && in_frame && !vif.mem_stall;
        exp_w = 0; exp_done = 0; a = 0; d = 0;
        if (acc) begin
            if (!flushing) begin
                exp_w = 1; a = wcount; d = beat_data[b];
                exp_sum += 32'(d);
                wcount++;
                last_addr = a;
                if (vif.s_last) begin
                    if (wcount < N) exp_early = 1;
                    in_frame = 0; exp_done = 1;
                end else if (wcount == N) begin
                    flushing = 1; exp_late = 1;
                end
            end else if (vif.s_last) begin
                in_frame = 0; exp_done = 1;
            end
            b++;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("wr_en", vif.wr_en, exp_w);
        if (exp_w) begin
            chk("wr_addr", vif.wr_addr, a);
            chk("wr_data", vif.wr_data, d);
            chk("pix_x", vif.pix_x, a % W);
            chk("pix_y", vif.pix_y, a / W);
        end
        chk("done", done, exp_done);
    endtask

    task automatic begin_frame(input int nb, input int la, input bit nominal);
        for (int i = 0; i < 32; i++)
            beat_data[i] = nominal ? 8'(i + 1) : 8'($urandom);
        nbeats = nb; last_at = la; b = 0;
        drive_idle();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        in_frame = 1; flushing = 0; exp_early = 0; exp_late = 0;
        wcount = 0; last_addr = 0; exp_sum = 0;
    endtask

    task automatic finish_frame(input bit stall_toggle, input bit gaps, input bit rnd_start);
        int guard = 0;
        while (in_frame && guard < 300) begin
            run_cycle(stall_toggle, gaps, rnd_start);
            guard++;
        end
        chk("frame_timeout", in_frame, 1'b0);
        for (int i = 0; i < 3; i++) run_cycle(stall_toggle, gaps, 1'b0);
        chk("err_early_last", err_early_last, exp_early);
        chk("err_late_last", err_late_last, exp_late);
        chk("frame_sum", frame_sum, exp_sum);
        chk("final_pix_x", vif.pix_x, last_addr % W);
        chk("final_pix_y", vif.pix_y, last_addr / W);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_s_ready"}, vif.s_ready, 0);
        chk({tag, "_wr_en"}, vif.wr_en, 0);
        chk({tag, "_wr_addr"}, vif.wr_addr, 0);
        chk({tag, "_wr_data"}, vif.wr_data, 0);
        chk({tag, "_pix_x"}, vif.pix_x, 0);
        chk({tag, "_pix_y"}, vif.pix_y, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_early"}, err_early_last, 0);
        chk({tag, "_late"}, err_late_last, 0);
        chk({tag, "_sum"}, frame_sum, 0);
    endtask

    initial begin
        drive_idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b1;
        @(posedge clk);
        #1;

        // nominal frame, pixels 1..12
        begin_frame(12, 12, 1'b1);
        finish_frame(1'b0, 1'b0, 1'b0);
        chk("nominal_sum_78", frame_sum, 32'd78);
        chk("nominal_last_x", vif.pix_x, 3);
        chk("nominal_last_y", vif.pix_y, 2);

        // backpressure with gaps, start pulses ignored mid-frame
        begin_frame(12, 12, 1'b0);
        finish_frame(1'b1, 1'b1, 1'b1);

        // early last on beat 7
        begin_frame(12, 7, 1'b0);
        finish_frame(1'b0, 1'b1, 1'b0);
        chk("early_flag", err_early_last, 1'b1);

        // missing last: 15 beats, last on beat 15
        begin_frame(15, 15, 1'b0);
        finish_frame(1'b1, 1'b0, 1'b1);
        chk("late_flag", err_late_last, 1'b1);

        // reset after 5 accepted beats, then a nominal frame
        begin_frame(12, 12, 1'b0);
        begin
            int guard = 0;
            while (b < 5 && guard < 100) begin
                run_cycle(1'b0, 1'b1, 1'b0);
                guard++;
            end
            chk("abort_timeout", b, 5);
        end
        drive_idle();
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk_reset_outputs("midreset");
        @(posedge clk);
        #1;
        chk_reset_outputs("midreset2");
        rst = 1'b1;
        in_frame = 0; b = nbeats;
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 1'b0, 1'b0);
        begin_frame(12, 12, 1'b1);
        finish_frame(1'b1, 1'b1, 1'b0);
        chk("restart_sum_78", frame_sum, 32'd78);

        // a few random frames with random last position and length
        for (int f = 0; f < 4; f++) begin
            int nb;
            nb = $urandom_range(3, 18);
            begin_frame(nb, $urandom_range(1, nb), 1'b0);
            finish_frame(1'($urandom), 1'($urandom), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/video_frame_capture.md
Name: video_frame_capture

Overview:
- Downstream sink for the 8-bit simulated video stream: consumes valid/ready/last beats for exactly one frame per `start`.
- Writes each accepted pixel to a frame-memory write port at a linear address.
- Tracks x/y coordinates and a running pixel sum, and flags frames whose `last` marker is early or missing.
- Sits between the stream source and the frame buffer consumed by the rectification stages.

Parameters:
- IMG_W, 640, pixels per line.
- IMG_H, 480, lines per frame (frame length N = IMG_W*IMG_H = 307200).
- DATA_W, 8, pixel width.
- ADDR_W, 19, memory address width; must satisfy 2^ADDR_W >= N.

Ports:
- clk  in  1  single system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  begin capturing one frame; sampled only in IDLE.
- s_data  in  DATA_W  stream pixel.
- s_valid  in  1  stream beat valid.
- s_last  in  1  stream end-of-frame marker.
- s_ready  out  1  sink ready.
- mem_stall  in  1  frame memory busy; blocks acceptance.
- wr_en  out  1  memory write strobe.
- wr_addr  out  ADDR_W  linear pixel address.
- wr_data  out  DATA_W  pixel written.
- pix_x  out  10  column of the pixel on wr_data.
- pix_y  out  9  row of the pixel on wr_data.
- busy  out  1  high in RECV or FLUSH.
- done  out  1  one-cycle pulse on frame completion.
- err_early_last  out  1  sticky: last seen before pixel N-1.
- err_late_last  out  1  sticky: pixel N-1 accepted without last.
- frame_sum  out  32  running unsigned sum of written pixels.

Behaviour:
- Reset (rst==0 at a clock edge): state=IDLE.
  - All outputs 0: s_ready, wr_en, wr_addr, wr_data, pix_x, pix_y, busy, done, both error flags, frame_sum.
  - Reset mid-frame abandons the frame; no done pulse.
- Handshake: a beat is accepted when s_valid && s_ready.
  - s_ready = (state==RECV || state==FLUSH) && !mem_stall. This is combinational from registered state and mem_stall.
  - s_data and s_last are not required to be held stable while s_ready is low.
- States:
  - IDLE: s_ready=0. When start=1, go to RECV. On that same edge clear cnt, x, y, frame_sum and both error flags.
  - RECV: each accepted beat does the following.
    - Registers wr_en=1, wr_addr=cnt, wr_data=s_data, pix_x=x, pix_y=y on the next edge. Write latency is exactly 1 cycle after acceptance.
    - frame_sum += s_data, at the same edge as the write.
    - Increments cnt. x wraps at IMG_W-1 to 0 and then increments y.
    - wr_en=0 in any cycle with no acceptance; the other write outputs hold their last value.
  - Beat with s_last && cnt==N-1: normal end, go to DONE.
  - Beat with s_last && cnt<N-1: write it, set err_early_last, go to DONE.
  - Beat with !s_last && cnt==N-1: write it, set err_late_last, go to FLUSH.
  - FLUSH: s_ready follows the rule above. Accepted beats are discarded (wr_en=0, no sum update) until a beat with s_last is accepted, then go to DONE.
  - DONE: done=1 for one cycle, s_ready=0, then go to IDLE. Error flags and frame_sum hold until the next start.
- start in any state other than IDLE is ignored.
- cnt is ADDR_W bits and never exceeds N-1 in RECV.
- frame_sum wraps modulo 2^32.
- busy = (state==RECV || state==FLUSH).

Decomposition:
- Shared package video_pkg holds:
  - IMG_W, IMG_H and FRAME_PIXELS (N) constants;
  - the capture state enum (IDLE, RECV, FLUSH, DONE);
  - the pixel type DATA_W.
- One natural sub-module: pixel_xy_counter (cnt/x/y with increment enable, clear, wrap, and terminal flag cnt==N-1), reusable by other stages.

Test Plan (small frames use IMG_W=4, IMG_H=3, N=12):
- Nominal frame, s_valid always 1, mem_stall=0, pixels 0x01..0x0C, last on beat 12.
  - 12 writes at addr 0..11, one cycle after each acceptance; final pix_x=3, pix_y=2.
  - frame_sum=78 (0x4E); one done pulse; no error flags.
- Backpressure: mem_stall toggled every other cycle and s_valid randomly gapped.
  - s_ready=0 exactly when mem_stall=1; data order and addresses identical to nominal.
  - No duplicated or dropped writes.
- Early last: last asserted on beat 7.
  - 7 writes (addr 0..6), err_early_last=1, done pulse, s_ready=0 afterwards.
- Missing last: 15 beats, last on beat 15.
  - 12 writes, err_late_last=1, beats 13..15 accepted with no writes, done after beat 15, frame_sum counts beats 1..12 only.
- Reset mid-frame: drive rst=0 after 5 beats, then start again with a nominal frame.
  - All outputs 0 during reset, no done pulse for the aborted frame.
  - Second frame restarts at addr 0 with correct frame_sum.
- Full-size frame (640x480) from the existing video source: 307200 writes, last address 307199, pix_x=639, pix_y=479.
  - frame_sum matches the sum of VIDEO.txt; done pulse; no errors.
